// File: rtl/shifter_pkg.sv
// Shared op codes and level/stage sizing helpers for the pipelined shifter.
package shifter_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // Number of binary shift levels needed for a power-of-two width.
  function automatic int unsigned log2_width(input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < width) n = i + 1;
    end
    return n;
  endfunction

  // Levels handled by a given stage; groups fill from the LSB level upward.
  function automatic int unsigned stage_levels(input int unsigned width,
                                               input int unsigned stages,
                                               input int unsigned stage);
    int unsigned lg;
    int unsigned per;
    int unsigned first;
    int unsigned last;
    lg    = log2_width(width);
    per   = (lg + stages - 1) / stages;
    first = stage * per;
    last  = first + per;
    if (first >= lg) return 0;
    if (last > lg) last = lg;
    return last - first;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational shift/rotate level: moves data by AMOUNT when enabled.
module shift_level
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AMOUNT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic [2:0]       oper,
  input  logic             sign,
  output logic [WIDTH-1:0] result_c
);

  // Select the shifted form for this level; invalid codes pass data through.
  always_comb begin
    result_c = data;
    if (enable) begin
      case (oper)
        OP_ROL:  result_c = {data[WIDTH-AMOUNT-1:0], data[WIDTH-1:WIDTH-AMOUNT]};
        OP_SLL:  result_c = {data[WIDTH-AMOUNT-1:0], {AMOUNT{1'b0}}};
        OP_ROR:  result_c = {data[AMOUNT-1:0], data[WIDTH-1:AMOUNT]};
        OP_SRL:  result_c = {{AMOUNT{1'b0}}, data[WIDTH-1:AMOUNT]};
        OP_SRA:  result_c = {{AMOUNT{sign}}, data[WIDTH-1:AMOUNT]};
        default: result_c = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and sideband tag.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [log2_width(WIDTH)-1:0] in_shamt,
  input  logic [2:0]                   in_oper,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_err,
  output logic [TAG_W-1:0]             out_tag
);

  localparam int unsigned SHW = log2_width(WIDTH);
  localparam int unsigned LPS = (SHW + PIPE_STAGES - 1) / PIPE_STAGES;

  // Stage inputs (combinational) and stage registers.
  logic             s_valid  [PIPE_STAGES];
  logic [WIDTH-1:0] s_data   [PIPE_STAGES];
  logic [SHW-1:0]   s_shamt  [PIPE_STAGES];
  logic [2:0]       s_oper   [PIPE_STAGES];
  logic             s_sign   [PIPE_STAGES];
  logic             s_err    [PIPE_STAGES];
  logic [TAG_W-1:0] s_tag    [PIPE_STAGES];
  logic [WIDTH-1:0] s_result [PIPE_STAGES];

  logic             r_valid  [PIPE_STAGES];
  logic [WIDTH-1:0] r_data   [PIPE_STAGES];
  logic [SHW-1:0]   r_shamt  [PIPE_STAGES];
  logic [2:0]       r_oper   [PIPE_STAGES];
  logic             r_sign   [PIPE_STAGES];
  logic             r_err    [PIPE_STAGES];
  logic [TAG_W-1:0] r_tag    [PIPE_STAGES];

  logic op_invalid;
  logic advance;

  assign op_invalid = (in_oper > OP_SRA);
  assign advance    = !r_valid[PIPE_STAGES-1] || out_ready;
  assign in_ready   = advance;

  // Feed stage 0 from the ports (invalid ops zeroed up front), later stages from the previous register.
  always_comb begin
    s_valid[0] = in_valid;
    s_data[0]  = op_invalid ? '0 : in_data;
    s_shamt[0] = in_shamt;
    s_oper[0]  = in_oper;
    s_sign[0]  = in_data[WIDTH-1] & ~op_invalid;
    s_err[0]   = op_invalid;
    s_tag[0]   = in_tag;
    for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
      s_valid[s] = r_valid[s-1];
      s_data[s]  = r_data[s-1];
      s_shamt[s] = r_shamt[s-1];
      s_oper[s]  = r_oper[s-1];
      s_sign[s]  = r_sign[s-1];
      s_err[s]   = r_err[s-1];
      s_tag[s]   = r_tag[s-1];
    end
  end

  // Binary levels; the first level of each stage takes that stage's input.
  for (genvar k = 0; k < SHW; k++) begin : g_level
    localparam int unsigned K  = k;
    localparam int unsigned ST = K / LPS;
    logic [WIDTH-1:0] lvl_in;
    logic [WIDTH-1:0] lvl_out;
    if ((K % LPS) == 0) begin : g_head
      assign lvl_in = s_data[ST];
    end else begin : g_chain
      assign lvl_in = g_level[k-1].lvl_out;
    end
    shift_level #(
      .WIDTH  (WIDTH),
      .AMOUNT (32'd1 << K)
    ) u_level (
      .data     (lvl_in),
      .enable   (s_shamt[ST][K]),
      .oper     (s_oper[ST]),
      .sign     (s_sign[ST]),
      .result_c (lvl_out)
    );
  end

  // Per-stage result: output of its last level, or pass-through for an empty stage.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int unsigned S  = s;
    localparam int unsigned NL = stage_levels(WIDTH, PIPE_STAGES, S);
    if (NL == 0) begin : g_empty
      assign s_result[s] = s_data[s];
    end else begin : g_full
      assign s_result[s] = g_level[S*LPS + NL - 1].lvl_out;
    end
  end

  // Stage registers: all advance together, all hold when the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_shamt[s] <= '0;
        r_oper[s]  <= '0;
        r_sign[s]  <= 1'b0;
        r_err[s]   <= 1'b0;
        r_tag[s]   <= '0;
      end
    end else if (advance) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        r_valid[s] <= s_valid[s];
        r_data[s]  <= s_result[s];
        r_shamt[s] <= s_shamt[s];
        r_oper[s]  <= s_oper[s];
        r_sign[s]  <= s_sign[s];
        r_err[s]   <= s_err[s];
        r_tag[s]   <= s_tag[s];
      end
    end
  end

  assign out_valid = r_valid[PIPE_STAGES-1];
  assign out_data  = r_data[PIPE_STAGES-1];
  assign out_err   = r_err[PIPE_STAGES-1];
  assign out_tag   = r_tag[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: 16-bit/2-stage and 32-bit/5-stage instances.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int unsigned W16  = 16;
  localparam int unsigned PS16 = 2;
  localparam int unsigned W32  = 32;
  localparam int unsigned PS32 = 5;
  localparam int unsigned TW   = 4;

  typedef struct packed {
    logic [63:0]   data;
    logic          err;
    logic [TW-1:0] tag;
    logic [31:0]   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0]   in_data, out_data;
  logic [3:0]    in_shamt;
  logic [2:0]    in_oper;
  logic [TW-1:0] in_tag, out_tag;

  logic          in_valid32, in_ready32, out_valid32, out_ready32, out_err32;
  logic [31:0]   in_data32, out_data32;
  logic [4:0]    in_shamt32;
  logic [2:0]    in_oper32;
  logic [TW-1:0] in_tag32, out_tag32;

  pipelined_shifter #(.WIDTH(W16), .PIPE_STAGES(PS16), .TAG_W(TW)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
    .in_oper(in_oper), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tag(out_tag)
  );

  pipelined_shifter #(.WIDTH(W32), .PIPE_STAGES(PS32), .TAG_W(TW)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_shamt(in_shamt32),
    .in_oper(in_oper32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_err(out_err32), .out_tag(out_tag32)
  );

  exp_t        q16[$];
  exp_t        q32[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  bit          lat_chk16 = 1'b1;
  bit          dir_has = 1'b0;
  logic [63:0] dir_exp = '0;
  bit          rand_rdy32 = 1'b0;

  logic [15:0] t_d [8] = '{16'h8001, 16'h0001, 16'h00FF, 16'h8000, 16'h8000, 16'h4000, 16'h1234, 16'h1234};
  logic [3:0]  t_s [8] = '{4'd1, 4'd4, 4'd8, 4'd15, 4'd15, 4'd14, 4'd3, 4'd0};
  logic [2:0]  t_o [8] = '{OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA, OP_SRA, 3'b111, OP_SLL};
  logic [15:0] t_e [8] = '{16'h0003, 16'h1000, 16'hFF00, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h1234};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference shifter written arithmetically over a w-bit field.
  function automatic logic [63:0] ref_op(input logic [63:0] d, input int unsigned sh,
                                         input logic [2:0] op, input int unsigned w);
    logic [63:0] m;
    logic [63:0] x;
    logic [63:0] r;
    m = (64'd1 << w) - 64'd1;
    x = d & m;
    case (op)
      3'd0: r = (x << sh) | (x >> (w - sh));
      3'd1: r = x << sh;
      3'd2: r = (x >> sh) | (x << (w - sh));
      3'd3: r = x >> sh;
      3'd4: begin
        r = x >> sh;
        if (x[w-1]) r = r | (m & ~(m >> sh));
      end
      default: r = '0;
    endcase
    return r & m;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure on the 32-bit instance.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready32 = rand_rdy32 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // 16-bit monitor: compare outputs, then record newly accepted ops.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q16.size() == 0) begin
          check("spurious16", 64'(out_valid), 64'd0);
        end else begin
          e = q16.pop_front();
          check("data16", 64'(out_data), e.data);
          check("err16", 64'(out_err), 64'(e.err));
          check("tag16", 64'(out_tag), 64'(e.tag));
          if (lat_chk16) check("lat16", 64'(cyc), 64'(e.due));
        end
      end
      if (rst_n && in_valid && in_ready) begin
        e.data = dir_has ? dir_exp : ref_op(64'(in_data), 32'(in_shamt), in_oper, W16);
        e.err  = (in_oper > OP_SRA);
        e.tag  = in_tag;
        e.due  = 32'(cyc + PS16);
        q16.push_back(e);
      end
    end
  end

  // 32-bit monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid32 && out_ready32) begin
        if (q32.size() == 0) begin
          check("spurious32", 64'(out_valid32), 64'd0);
        end else begin
          e = q32.pop_front();
          check("data32", 64'(out_data32), e.data);
          check("err32", 64'(out_err32), 64'(e.err));
          check("tag32", 64'(out_tag32), 64'(e.tag));
        end
      end
      if (rst_n && in_valid32 && in_ready32) begin
        e.data = ref_op(64'(in_data32), 32'(in_shamt32), in_oper32, W32);
        e.err  = (in_oper32 > OP_SRA);
        e.tag  = in_tag32;
        e.due  = 32'(cyc + PS32);
        q32.push_back(e);
      end
    end
  end

  task automatic send16(input logic [15:0] d, input logic [3:0] sh, input logic [2:0] op,
                        input logic [TW-1:0] tg, output int waited);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_oper = op; in_tag = tg;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("send16_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op,
                        input logic [TW-1:0] tg);
    int waited;
    in_valid32 = 1'b1; in_data32 = d; in_shamt32 = sh; in_oper32 = op; in_tag32 = tg;
    waited = 0;
    @(negedge clk);
    while (!in_ready32 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready32) check("send32_timeout", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
  endtask

  task automatic drain16();
    for (int i = 0; i < 60 && q16.size() != 0; i++) @(negedge clk);
    check("drain16", 64'(q16.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clk);
    check("drain32", 64'(q32.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_oper = '0; in_tag = '0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_data32 = '0; in_shamt32 = '0; in_oper32 = '0; in_tag32 = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single ops, each isolated to check latency.
    for (int i = 0; i < 8; i++) begin
      dir_has = 1'b1;
      dir_exp = 64'(t_e[i]);
      send16(t_d[i], t_s[i], t_o[i], 4'(i), w);
      dir_has = 1'b0;
      drain16();
    end

    // Back-to-back issue with tags 0..7.
    for (int i = 0; i < 8; i++) begin
      send16(16'($urandom), 4'($urandom), 3'(i % 5), 4'(i), w);
      check("b2b_ready", 64'(w), 64'd0);
    end
    drain16();

    // Backpressure with two ops in flight.
    lat_chk16 = 1'b0;
    out_ready = 1'b0;
    send16(16'hA5A5, 4'd4, OP_ROL, 4'hA, w);
    send16(16'h0F0F, 4'd2, OP_SRL, 4'hB, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h5A5A);
      check("bp_tag", 64'(out_tag), 64'hA);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain16();
    lat_chk16 = 1'b1;

    // Asynchronous reset with two ops in flight.
    send16(16'h1111, 4'd1, OP_SLL, 4'd1, w);
    send16(16'h2222, 4'd1, OP_SLL, 4'd2, w);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    q16.delete();
    q32.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    dir_has = 1'b1;
    dir_exp = 64'h000F;
    send16(16'h00F0, 4'd4, OP_ROR, 4'd5, w);
    dir_has = 1'b0;
    drain16();

    // Full sweep on the 16-bit instance.
    for (int op = 0; op < 8; op++) begin
      for (int sh = 0; sh < 16; sh++) begin
        send16(16'($urandom), 4'(sh), 3'(op), 4'($urandom), w);
      end
    end
    drain16();

    // Full sweep on the 32-bit/5-stage instance under random backpressure.
    rand_rdy32 = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int sh = 0; sh < 32; sh++) begin
        send32(32'($urandom), 5'(sh), 3'(op), 4'($urandom));
      end
    end
    rand_rdy32 = 1'b0;
    drain32();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
